// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: two-client round-robin sequencer for a single-port memory
module mem_arbiter_2p #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          mem_op,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t        state, state_next;
    logic          owner, owner_next;
    logic          last_gnt, last_next;
    logic          pick;
    logic          op_next, ack0_next, ack1_next;
    logic [AW-1:0] addr_next;
    logic [DW-1:0] wdata_next, rdata0_next, rdata1_next;

    // next-state and next-output decode; last_gnt only moves on a real tie
    always_comb begin
        state_next  = state;
        owner_next  = owner;
        last_next   = last_gnt;
        op_next     = mem_op;
        addr_next   = mem_addr;
        wdata_next  = mem_wdata;
        ack0_next   = 1'b0;
        ack1_next   = 1'b0;
        rdata0_next = rdata0;
        rdata1_next = rdata1;
        pick        = (req0 && req1) ? ~last_gnt : req1;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_next = ISSUE;
                    owner_next = pick;
                    last_next  = (req0 && req1) ? pick : last_gnt;
                    op_next    = pick ? we1 : we0;
                    addr_next  = pick ? addr1 : addr0;
                    wdata_next = pick ? wdata1 : wdata0;
                end
            end
            ISSUE: begin
                state_next  = DONE;
                op_next     = 1'b0;
                ack0_next   = !owner;
                ack1_next   = owner;
                rdata0_next = (!owner && !mem_op) ? mem_rdata : rdata0;
                rdata1_next = (owner && !mem_op) ? mem_rdata : rdata1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // state and registered outputs; reset abandons any in-flight op
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last_gnt  <= 1'b1;
            mem_op    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            last_gnt  <= last_next;
            mem_op    <= op_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            ack0      <= ack0_next;
            ack1      <= ack1_next;
            rdata0    <= rdata0_next;
            rdata1    <= rdata1_next;
            busy      <= state_next != IDLE;
        end
    end
endmodule
